instruction_fetch: RTL and testbench

Fetch stage of the CHIP-8 core: owns the program counter and reads each 16-bit big-endian opcode as two byte reads from the shared 4 KiB byte-wide RAM. It then presents the opcode and its address to decode/execute over a valid/ready handshake. It sits upstream of decode/execute, which in turn feeds `memory_access`, and accepts PC redirects (jumps, calls, returns, skips) from execute.

---
 rtl/chip8_pkg.sv | 19 +
 rtl/instruction_fetch_if.sv | 44 ++++
 rtl/instruction_fetch.sv | 75 +++++++
 tb/tb_instruction_fetch.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/chip8_pkg.sv
// rtl/chip8_pkg.sv - shared CHIP-8 core types and constants
package chip8_pkg;

    localparam int ADDR_W = 12;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [15:0]       opcode_t;

    localparam addr_t RESET_PC = 12'h200;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HI,
        S_LO,
        S_CAP,
        S_OUT
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_if.sv
// rtl/instruction_fetch_if.sv - fetch stage bus: RAM read port, opcode handshake, redirect
interface instruction_fetch_if;
    import chip8_pkg::*;

    // redirect from execute
    logic    pc_load;
    addr_t   pc_target;

    // byte-wide RAM read port
    logic    mem_rd_en;
    addr_t   mem_addr;
    logic [7:0] mem_rd_data;

    // opcode handshake to decode/execute
    logic    instr_valid;
    logic    instr_ready;
    opcode_t instr;
    addr_t   instr_pc;

    modport master (
        input  pc_load,
        input  pc_target,
        output mem_rd_en,
        output mem_addr,
        input  mem_rd_data,
        output instr_valid,
        input  instr_ready,
        output instr,
        output instr_pc
    );

    modport slave (
        output pc_load,
        output pc_target,
        input  mem_rd_en,
        input  mem_addr,
        output mem_rd_data,
        input  instr_valid,
        output instr_ready,
        input  instr,
        input  instr_pc
    );

endinterface

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - CHIP-8 fetch stage: PC, two byte reads per opcode, valid/ready output
module instruction_fetch
    import chip8_pkg::*;
(
    input  logic clk,
    input  logic rst,
    instruction_fetch_if.master bus
);

    fetch_state_t state;
    addr_t        pc;
    logic [7:0]   hi_byte;

    // Fetch FSM; all bus outputs are registered alongside the state so none
    // of them sees instr_ready or pc_load combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            pc              <= RESET_PC;
            hi_byte         <= '0;
            bus.instr       <= '0;
            bus.instr_pc    <= '0;
            bus.mem_rd_en   <= 1'b0;
            bus.mem_addr    <= '0;
            bus.instr_valid <= 1'b0;
        end else if (bus.pc_load) begin
            // Redirect wins over everything, including a same-cycle handshake;
            // the read to the new target goes out on the very next cycle.
            pc              <= bus.pc_target;
            state           <= S_HI;
            bus.mem_rd_en   <= 1'b1;
            bus.mem_addr    <= bus.pc_target;
            bus.instr_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    state         <= S_HI;
                    bus.mem_rd_en <= 1'b1;
                    bus.mem_addr  <= pc;
                end
                S_HI: begin
                    state         <= S_LO;
                    bus.mem_rd_en <= 1'b1;
                    bus.mem_addr  <= pc + addr_t'(1);
                end
                S_LO: begin
                    hi_byte       <= bus.mem_rd_data;
                    state         <= S_CAP;
                    bus.mem_rd_en <= 1'b0;
                end
                S_CAP: begin
                    bus.instr       <= {hi_byte, bus.mem_rd_data};
                    bus.instr_pc    <= pc;
                    state           <= S_OUT;
                    bus.instr_valid <= 1'b1;
                end
                S_OUT: begin
                    if (bus.instr_ready) begin
                        pc              <= pc + addr_t'(2);
                        state           <= S_HI;
                        bus.instr_valid <= 1'b0;
                        bus.mem_rd_en   <= 1'b1;
                        bus.mem_addr    <= pc + addr_t'(2);
                    end
                end
                default: begin
                    state           <= S_IDLE;
                    bus.mem_rd_en   <= 1'b0;
                    bus.instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - scoreboard bench for instruction_fetch
module tb_instruction_fetch;
    import chip8_pkg::*;

    logic clk;
    logic rst;

    instruction_fetch_if bus ();

    instruction_fetch dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] ram [0:4095];

    // synchronous RAM: data valid one cycle after the strobe
    always @(posedge clk) begin
        if (bus.mem_rd_en)
            bus.mem_rd_data <= ram[bus.mem_addr];
    end

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [15:0] op;
        logic [15:0] pc;
    } exp_t;

    exp_t exp_q[$];

    function automatic void check(string name, logic [15:0] act, logic [15:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endfunction

    // monitor: every accepted opcode is compared against the scoreboard
    always @(negedge clk) begin
        if (!rst && bus.instr_valid && bus.instr_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_opcode: got %h @ %h, expected none", bus.instr, bus.instr_pc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_instr", bus.instr, e.op);
                check("sb_instr_pc", 16'(bus.instr_pc), e.pc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(string name, int max_cycles);
        int n;
        n = 0;
        while (!bus.instr_valid && n < max_cycles) begin
            tick();
            n++;
        end
        check(name, 16'(bus.instr_valid), 16'd1);
    endtask

    task automatic check_reset_vals(string tag);
        check({tag, "_rd_en"}, 16'(bus.mem_rd_en), 16'd0);
        check({tag, "_addr"}, 16'(bus.mem_addr), 16'h000);
        check({tag, "_valid"}, 16'(bus.instr_valid), 16'd0);
        check({tag, "_instr"}, bus.instr, 16'h0000);
        check({tag, "_instr_pc"}, 16'(bus.instr_pc), 16'h000);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        ram[12'h200] = 8'h12; ram[12'h201] = 8'h34;
        ram[12'h202] = 8'h56; ram[12'h203] = 8'h78;
        ram[12'h204] = 8'h99; ram[12'h205] = 8'h88;
        ram[12'h300] = 8'hA2; ram[12'h301] = 8'h0F;
        ram[12'h2A4] = 8'h6A; ram[12'h2A5] = 8'h05;
        ram[12'hFFF] = 8'hAB; ram[12'h000] = 8'hCD;

        rst             = 1'b1;
        bus.pc_load     = 1'b0;
        bus.pc_target   = '0;
        bus.instr_ready = 1'b1;

        // reset state and first fetch
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        exp_q.push_back('{op: 16'h1234, pc: 16'h200});
        rst = 1'b0;
        tick();
        check("e1_rd_en", 16'(bus.mem_rd_en), 16'd1);
        check("e1_addr", 16'(bus.mem_addr), 16'h200);
        tick();
        check("e2_rd_en", 16'(bus.mem_rd_en), 16'd1);
        check("e2_addr", 16'(bus.mem_addr), 16'h201);
        tick();
        check("e3_valid", 16'(bus.instr_valid), 16'd0);
        check("e3_rd_en", 16'(bus.mem_rd_en), 16'd0);
        tick();
        check("e4_valid", 16'(bus.instr_valid), 16'd1);
        check("e4_instr", bus.instr, 16'h1234);
        check("e4_instr_pc", 16'(bus.instr_pc), 16'h200);
        tick();
        check("e5_addr", 16'(bus.mem_addr), 16'h202);
        check("e5_rd_en", 16'(bus.mem_rd_en), 16'd1);
        check("e5_valid", 16'(bus.instr_valid), 16'd0);
        bus.instr_ready = 1'b0;

        // backpressure in S_OUT
        exp_q.push_back('{op: 16'h5678, pc: 16'h202});
        wait_valid("bp_valid", 8);
        check("bp_instr", bus.instr, 16'h5678);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_hold_valid", 16'(bus.instr_valid), 16'd1);
            check("bp_hold_instr", bus.instr, 16'h5678);
            check("bp_hold_pc", 16'(bus.instr_pc), 16'h202);
            check("bp_hold_rd_en", 16'(bus.mem_rd_en), 16'd0);
        end
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        check("bp_next_addr", 16'(bus.mem_addr), 16'h204);
        check("bp_next_rd_en", 16'(bus.mem_rd_en), 16'd1);

        // redirect during S_LO
        tick();
        check("lo_addr", 16'(bus.mem_addr), 16'h205);
        bus.pc_load   = 1'b1;
        bus.pc_target = 12'h300;
        tick();
        bus.pc_load = 1'b0;
        check("redir_valid", 16'(bus.instr_valid), 16'd0);
        check("redir_rd_en", 16'(bus.mem_rd_en), 16'd1);
        check("redir_addr", 16'(bus.mem_addr), 16'h300);
        exp_q.push_back('{op: 16'hA20F, pc: 16'h300});
        wait_valid("redir_out_valid", 8);
        check("redir_instr", bus.instr, 16'hA20F);
        check("redir_instr_pc", 16'(bus.instr_pc), 16'h300);

        // pc_load together with the handshake
        bus.instr_ready = 1'b1;
        bus.pc_load     = 1'b1;
        bus.pc_target   = 12'h2A4;
        tick();
        bus.instr_ready = 1'b0;
        bus.pc_load     = 1'b0;
        check("both_valid", 16'(bus.instr_valid), 16'd0);
        check("both_addr", 16'(bus.mem_addr), 16'h2A4);
        exp_q.push_back('{op: 16'h6A05, pc: 16'h2A4});
        wait_valid("both_out_valid", 8);
        check("both_instr", bus.instr, 16'h6A05);

        // redirect drops the held opcode unconsumed; that consumes its scoreboard slot
        void'(exp_q.pop_back());
        bus.pc_load   = 1'b1;
        bus.pc_target = 12'hFFF;
        tick();
        bus.pc_load = 1'b0;
        check("wrap_addr_hi", 16'(bus.mem_addr), 16'hFFF);
        tick();
        check("wrap_addr_lo", 16'(bus.mem_addr), 16'h000);
        exp_q.push_back('{op: 16'hABCD, pc: 16'hFFF});
        wait_valid("wrap_valid", 8);
        check("wrap_instr", bus.instr, 16'hABCD);
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        check("wrap_next_addr", 16'(bus.mem_addr), 16'h001);

        // asynchronous reset in the middle of S_CAP
        tick();
        tick();
        check("cap_rd_en", 16'(bus.mem_rd_en), 16'd0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals("async");
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        check("refetch_rd_en", 16'(bus.mem_rd_en), 16'd1);
        check("refetch_addr", 16'(bus.mem_addr), 16'h200);
        exp_q.push_back('{op: 16'h1234, pc: 16'h200});
        wait_valid("refetch_valid", 8);
        bus.instr_ready = 1'b1;
        tick();
        bus.instr_ready = 1'b0;
        tick();

        check("sb_drained", 16'(exp_q.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
